// File: rtl/counter_pkg.sv
// counter_pkg
//    Shared sizing and limit constants for the 4-bit up/down counter slice.
//    WIDTH : counter width in bits
//    Q_MAX : upper limit (increment wraps or saturates here)
//    Q_MIN : lower limit (decrement wraps or saturates here)
package counter_pkg;

   localparam int WIDTH = 4;

   typedef logic [WIDTH-1:0] cnt_t;

   localparam cnt_t Q_MAX = 4'hF;
   localparam cnt_t Q_MIN = 4'h0;

endpackage : counter_pkg

// File: rtl/inc_dec4.sv
// inc_dec4
//    Purely combinational next-value and limit detect for one counter stage.
//    a        : current counter value
//    up       : 1 = increment, 0 = decrement
//    s        : a+1 or a-1, modulo 2**WIDTH
//    at_limit : a is at the limit for the selected direction
//               (Q_MAX when counting up, Q_MIN when counting down)
module inc_dec4
   import counter_pkg::*;
(
   input  logic [WIDTH-1:0] a,
   input  logic             up,
   output logic [WIDTH-1:0] s,
   output logic             at_limit
);

   always_comb begin
      s        = a;
      at_limit = 1'b0;
      if (up) begin
         s        = a + cnt_t'(1);
         at_limit = (a == Q_MAX);
      end else begin
         s        = a - cnt_t'(1);
         at_limit = (a == Q_MIN);
      end
   end

endmodule : inc_dec4

// File: rtl/counter_inc_dec4.sv
// counter_inc_dec4
//    Cascadable 4-bit up/down counter with parallel load, optional
//    saturation, a one-cycle terminal-count pulse and a sticky overflow flag.
//    clk      : clock, all state updates on the rising edge
//    rst_n    : asynchronous active-low reset
//    en       : count enable
//    cin      : cascade enable from the lower stage (step needs en & cin)
//    up       : direction, 1 = increment, 0 = decrement
//    load     : synchronous parallel load (highest priority)
//    din      : load value
//    sat      : 1 = saturate at the limits, 0 = wrap modulo 16
//    clr_ovf  : clears the sticky overflow flag (a same-cycle event wins)
//    q        : counter value
//    cout_inc : combinational carry out, feeds the next stage's cin
//    cout_dec : combinational borrow out, feeds the next stage's cin
//    tc       : registered pulse, high the cycle after a wrap/saturation event
//    ovf      : sticky flag set by any wrap/saturation event
module counter_inc_dec4
   import counter_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             cin,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] din,
   input  logic             sat,
   input  logic             clr_ovf,
   output logic [WIDTH-1:0] q,
   output logic             cout_inc,
   output logic             cout_dec,
   output logic             tc,
   output logic             ovf
);

   cnt_t q_reg, q_next;
   logic tc_reg, tc_next;
   logic ovf_reg, ovf_next;

   cnt_t step_val;
   logic at_limit;
   logic step;
   logic limit_evt;

   inc_dec4 u_inc_dec4 (
      .a        (q_reg),
      .up       (up),
      .s        (step_val),
      .at_limit (at_limit)
   );

   always_comb begin
      step      = en & cin & ~load;
      // A step taken at a limit is an event whether it wraps or saturates.
      limit_evt = step & at_limit;

      q_next = q_reg;
      if (load) begin
         q_next = din;
      end else if (step && !(sat && at_limit)) begin
         q_next = step_val;
      end

      tc_next  = limit_evt;
      // Set dominates clear so a colliding event is never lost.
      ovf_next = limit_evt | (ovf_reg & ~clr_ovf);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q_reg   <= Q_MIN;
         tc_reg  <= 1'b0;
         ovf_reg <= 1'b0;
      end else begin
         q_reg   <= q_next;
         tc_reg  <= tc_next;
         ovf_reg <= ovf_next;
      end
   end

   // Carry/borrow stay unregistered so stages chain within one cycle; rst_n
   // gates them so a stage in reset cannot step its neighbour.
   assign cout_inc = rst_n & en & cin &  up & (q_reg == Q_MAX) & ~load;
   assign cout_dec = rst_n & en & cin & ~up & (q_reg == Q_MIN) & ~load;

   assign q   = q_reg;
   assign tc  = tc_reg;
   assign ovf = ovf_reg;

endmodule : counter_inc_dec4

// File: doc/counter_inc_dec4.md
COUNTER_INC_DEC4 -- requirements
Module: counter_inc_dec4

Interface
REQ-001 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-003 SHALL have port en, input, 1, count enable.
REQ-004 SHALL have port cin, input, 1, cascade enable from the lower stage; a count step requires en=1 and cin=1.
REQ-005 SHALL have port up, input, 1, direction: 1 = increment, 0 = decrement.
REQ-006 SHALL have port load, input, 1, synchronous parallel load.
REQ-007 SHALL have port din, input, 4, load value.
REQ-008 SHALL have port sat, input, 1, mode: 1 = saturate at the limits, 0 = wrap modulo 16.
REQ-009 SHALL have port clr_ovf, input, 1, clears the sticky overflow flag.
REQ-010 SHALL have port q, output, 4, counter value.
REQ-011 SHALL have port cout_inc, output, 1, combinational carry: en & cin & up & (q==4'hF) & ~load.
REQ-012 SHALL have port cout_dec, output, 1, combinational borrow: en & cin & ~up & (q==4'h0) & ~load.
REQ-013 SHALL have port tc, output, 1, registered one-cycle pulse that follows any wrap or saturation event.
REQ-014 SHALL have port ovf, output, 1, sticky flag set by any wrap or saturation event.

Function
REQ-015 SHALL apply this priority each cycle: load, then count step, then hold.
REQ-016 SHALL set q to din on the next edge when load=1, regardless of en, cin, up and sat.
REQ-017 SHALL, on a count step with up=1, set q to q+1 mod 16; with sat=1 and q=4'hF, q SHALL hold at 4'hF.
REQ-018 SHALL, on a count step with up=0, set q to q-1 mod 16; with sat=1 and q=4'h0, q SHALL hold at 4'h0.
REQ-019 SHALL define an event as a count step at a limit: up at 4'hF or down at 4'h0, in either mode.
REQ-020 SHALL drive tc=1 for exactly the one cycle after an event; otherwise tc=0.
REQ-021 SHALL set ovf on the edge after an event, and keep it set until clr_ovf=1.
REQ-022 SHALL let set win when clr_ovf and an event occur in the same cycle.
REQ-023 SHALL produce no event in a load cycle, even when q is at a limit.
REQ-024 SHALL produce no event and no change in q when en=0 or cin=0.
REQ-025 SHALL allow up to change every cycle, taking effect on the same edge with no latency penalty.
REQ-026 SHALL drive cout_inc and cout_dec with no register stage, so that N stages chain by connecting cout into the next stage's cin.

Reset
REQ-027 SHALL, while rst_n=0, immediately force q=4'h0, tc=0 and ovf=0.
REQ-028 SHALL, while rst_n=0, force cout_inc=0 and cout_dec=0, regardless of the combinational terms.
REQ-029 SHALL resume on the first rising clk edge after rst_n deasserts, with no extra cycles.
REQ-030 SHALL discard any load or count step in progress when reset asserts mid-operation.

Structure
REQ-031 SHALL take WIDTH=4, Q_MAX=4'hF and Q_MIN=4'h0 from the shared package counter_pkg.
REQ-032 SHALL compute the next value and the limit detect in one combinational sub-module, inc_dec4, with these signals:
- inputs: a[3:0], up
- outputs: s[3:0], at_limit
REQ-033 SHALL hold the registers for q, tc and ovf in the top level, with no further sub-modules.

Verification
REQ-034 SHALL cover reset then count: rst_n low then high, en=cin=up=1, sat=0, 17 edges -> q counts 1..15, 0, 1; cout_inc=1 while q=4'hF; tc=1 one cycle after the wrap; ovf=1.
REQ-035 SHALL cover saturation down: load din=4'h1, then sat=1, up=0, 3 steps -> q=0, 0, 0; tc pulses after steps 2 and 3; ovf=1.
REQ-036 SHALL cover load priority: q=4'hF, load=1, din=4'h5, en=cin=up=1 -> q=4'h5, cout_inc=0, tc=0, ovf unchanged.
REQ-037 SHALL cover clear/set collision: ovf=1, q=4'h0, up=0, en=cin=1, clr_ovf=1 -> q=4'hF and ovf stays 1; next cycle with clr_ovf=1 and no event -> ovf=0.
REQ-038 SHALL cover cascade: two instances, low cout_inc into high cin, up=1 from 8'h00 for 256 steps -> combined value wraps to 8'h00; the high stage's tc pulses once.
REQ-039 SHALL cover reset mid-count: rst_n pulsed low between edges with q=4'h9 -> q=0, tc=0, ovf=0 at once, with no clock edge needed.
